// File: rtl/sram_arbiter_mc_if.sv
// sram_arbiter_mc_if: channel, stream and SRAM-pin bundle for sram_arbiter_mc.
//   master: request side plus pin observer (drives ch_*/stream_* requests).
//   slave : the arbiter (drives grants, status flags and SRAM pins).
interface sram_arbiter_mc_if #(
  parameter int NCH = 3,
  parameter int AW  = 19
);
  logic [NCH-1:0]    ch_req;
  logic [NCH-1:0]    ch_we;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*8-1:0]  ch_wdata;
  logic [NCH-1:0]    ch_latchen;
  logic [NCH-1:0]    ch_valid;
  logic [NCH-1:0]    ch_wait;
  logic              stream_req;
  logic [AW-1:0]     stream_addr;
  logic              stream_ack;
  logic              stream_valid;
  logic [AW-1:0]     va;
  logic [7:0]        vd_out;
  logic              n_vrd;
  logic              n_vwr;
  modport master (
    output ch_req, ch_we, ch_addr, ch_wdata, stream_req, stream_addr,
    input  ch_latchen, ch_valid, ch_wait, stream_ack, stream_valid, va, vd_out, n_vrd, n_vwr
  );
  modport slave (
    input  ch_req, ch_we, ch_addr, ch_wdata, stream_req, stream_addr,
    output ch_latchen, ch_valid, ch_wait, stream_ack, stream_valid, va, vd_out, n_vrd, n_vwr
  );
endinterface

// File: rtl/sram_arbiter_mc.sv
// sram_arbiter_mc: NCH edge-triggered read/write channels plus a preemptible stream read onto one async 8-bit SRAM.
//   clk28, rst (async, active-high); bus: sram_arbiter_mc_if.slave carrying channel requests/status,
//   stream request/status and the SRAM pins (va, vd_out, n_vrd, n_vwr).
//   SRAM_ARB_RR_EN defined: round-robin channel selection; undefined: fixed priority, channel 0 highest.
module sram_arbiter_mc #(
  parameter int NCH        = 3,
  parameter int AW         = 19,
  parameter int LAT        = 2,
  parameter int LAT_STREAM = 1
) (
  input logic clk28,
  input logic rst,
  sram_arbiter_mc_if.slave bus
);
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {NONE, CH, STREAM} kind_t;
  kind_t kind, kind_n;
  logic [IW-1:0]  idx, idx_n, sel;
  logic [1:0]     step, step_n;
  logic [AW-1:0]  va, va_n;
  logic [7:0]     vd, vd_n;
  logic           n_vrd, n_vrd_n, n_vwr, n_vwr_n;
  logic [NCH-1:0] req0, req0_n, latchen, latch_n, sticky, sticky_n;
  logic [NCH-1:0] rise, mis, valid, wait_o;
  logic           any_rise, dec;
`ifdef SRAM_ARB_RR_EN
  logic [IW-1:0]  ptr, ptr_n;
`endif
  assign rise     = bus.ch_req & ~req0;
  assign any_rise = |rise;
  // a pending channel edge may cut short a stream read at any step
  assign dec      = step == 2'd0 || (kind == STREAM && any_rise);
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign mis[g]    = kind == CH && idx == IW'(g) && step != 2'd0 && bus.ch_addr[g*AW +: AW] != va;
    assign valid[g]  = kind == CH && idx == IW'(g) && step == 2'd0;
    assign wait_o[g] = mis[g] | (sticky[g] & ~valid[g]);
  end
  always_comb begin
    sel = '0;
`ifdef SRAM_ARB_RR_EN
    for (int k = NCH - 1; k >= 0; k--)
      if (rise[(int'(ptr) + k) % NCH]) sel = IW'((int'(ptr) + k) % NCH);
`else
    for (int k = NCH - 1; k >= 0; k--)
      if (rise[k]) sel = IW'(k);
`endif
  end
  always_comb begin
    kind_n   = kind;
    idx_n    = idx;
    step_n   = step;
    va_n     = va;
    vd_n     = vd;
    n_vrd_n  = n_vrd;
    n_vwr_n  = n_vwr;
    req0_n   = req0;
    latch_n  = latchen;
    sticky_n = (sticky | mis) & ~valid;
`ifdef SRAM_ARB_RR_EN
    ptr_n    = ptr;
`endif
    if (dec) begin
      latch_n = '0;
      // losing edges keep their old req0 bit so they stay pending
      for (int k = 0; k < NCH; k++)
        req0_n[k] = (rise[k] && IW'(k) != sel) ? req0[k] : bus.ch_req[k];
      if (any_rise) begin
        idx_n   = sel;
        va_n    = bus.ch_addr[int'(sel)*AW +: AW];
        step_n  = 2'(LAT);
        n_vwr_n = ~bus.ch_we[sel];
        n_vrd_n = bus.ch_we[sel];
        kind_n  = bus.ch_we[sel] ? NONE : CH;
        vd_n    = bus.ch_we[sel] ? bus.ch_wdata[int'(sel)*8 +: 8] : vd;
        latch_n[sel] = ~bus.ch_we[sel];
`ifdef SRAM_ARB_RR_EN
        ptr_n   = sel == IW'(NCH - 1) ? '0 : sel + 1'b1;
`endif
      end else begin
        va_n    = bus.stream_req ? bus.stream_addr : va;
        step_n  = bus.stream_req ? 2'(LAT_STREAM) : 2'd0;
        kind_n  = bus.stream_req ? STREAM : NONE;
        n_vrd_n = ~bus.stream_req;
        n_vwr_n = 1'b1;
      end
    end else if (|mis) begin
      va_n   = bus.ch_addr[int'(idx)*AW +: AW];
      step_n = 2'(LAT);
    end else begin
      step_n = step - 2'd1;
    end
  end
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      kind    <= NONE;
      idx     <= '0;
      step    <= '0;
      va      <= '0;
      vd      <= '0;
      n_vrd   <= 1'b1;
      n_vwr   <= 1'b1;
      req0    <= '0;
      latchen <= '0;
      sticky  <= '0;
`ifdef SRAM_ARB_RR_EN
      ptr     <= '0;
`endif
    end else begin
      kind    <= kind_n;
      idx     <= idx_n;
      step    <= step_n;
      va      <= va_n;
      vd      <= vd_n;
      n_vrd   <= n_vrd_n;
      n_vwr   <= n_vwr_n;
      req0    <= req0_n;
      latchen <= latch_n;
      sticky  <= sticky_n;
`ifdef SRAM_ARB_RR_EN
      ptr     <= ptr_n;
`endif
    end
  end
  assign bus.va           = va;
  assign bus.vd_out       = vd;
  assign bus.n_vrd        = n_vrd;
  assign bus.n_vwr        = n_vwr;
  assign bus.ch_latchen   = latchen;
  assign bus.ch_valid     = valid;
  assign bus.ch_wait      = wait_o;
  assign bus.stream_valid = kind == STREAM && step == 2'd0;
  assign bus.stream_ack   = kind == STREAM && step == 2'd1 && !any_rise;
endmodule

// File: tb/tb_sram_arbiter_mc.sv
// tb_sram_arbiter_mc: directed bench with an access scoreboard for sram_arbiter_mc (NCH=3, AW=19, LAT=2, LAT_STREAM=1).
module tb_sram_arbiter_mc;
  localparam int NCH = 3;
  localparam int AW  = 19;
  localparam int WR  = 8;
  localparam int ST  = 9;
  typedef struct {
    int          src;
    logic [18:0] addr;
    logic [7:0]  data;
  } exp_t;
  logic clk28 = 1'b0;
  logic rst   = 1'b1;
  logic prev_vwr = 1'b1;
  int   n_tot = 0;
  int   n_bad = 0;
  int   cnt;
  exp_t sb[$];
  sram_arbiter_mc_if #(.NCH(NCH), .AW(AW)) bus ();
  sram_arbiter_mc #(.NCH(NCH), .AW(AW), .LAT(2), .LAT_STREAM(1)) dut (
    .clk28(clk28),
    .rst  (rst),
    .bus  (bus)
  );
  always #5 clk28 = ~clk28;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input int src, input logic [18:0] addr, input logic [7:0] data);
    exp_t e;
    e.src  = src;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask
  task automatic set_ch(input int i, input logic we, input logic [18:0] addr, input logic [7:0] data);
    bus.ch_we[i]            = we;
    bus.ch_addr[i*AW +: AW] = addr;
    bus.ch_wdata[i*8 +: 8]  = data;
  endtask
  always @(negedge clk28) begin
    int   src;
    exp_t e;
    src = -1;
    if (!rst) begin
      if (bus.n_vwr === 1'b0 && prev_vwr) src = WR;
      else if (bus.stream_valid === 1'b1) src = ST;
      else for (int i = NCH - 1; i >= 0; i--) if (bus.ch_valid[i] === 1'b1) src = i;
      if (src >= 0) begin
        if (sb.size() == 0) chk("sb_unexpected", 32'(src), 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          chk("sb_src", 32'(src), 32'(e.src));
          chk("sb_addr", 32'(bus.va), 32'(e.addr));
          if (src == WR) chk("sb_data", 32'(bus.vd_out), 32'(e.data));
        end
      end
    end
    prev_vwr = bus.n_vwr;
  end
  initial begin
    bus.ch_req      = '0;
    bus.ch_we       = '0;
    bus.ch_addr     = '0;
    bus.ch_wdata    = '0;
    bus.stream_req  = 1'b0;
    bus.stream_addr = '0;
    repeat (2) @(negedge clk28);
    chk("rst_va", 32'(bus.va), 0);
    chk("rst_vd", 32'(bus.vd_out), 0);
    chk("rst_nvrd", 32'(bus.n_vrd), 1);
    chk("rst_nvwr", 32'(bus.n_vwr), 1);
    chk("rst_flags", {bus.ch_latchen, bus.ch_valid, bus.ch_wait, bus.stream_ack, bus.stream_valid}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk28);
    // ch1 write: strobe low 3 cycles, no read valid
    set_ch(1, 1'b1, 19'h12345, 8'hA5);
    bus.ch_req[1] = 1'b1;
    push(WR, 19'h12345, 8'hA5);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk28);
      if (bus.n_vwr === 1'b0) cnt++;
      if (i == 0) chk("wr_nvrd", 32'(bus.n_vrd), 1);
      chk("wr_novalid", 32'(bus.ch_valid), 0);
    end
    chk("wr_len", 32'(cnt), 3);
    bus.ch_req[1] = 1'b0;
    bus.ch_we[1]  = 1'b0;
    repeat (2) @(negedge clk28);
    // ch0 read: valid two cycles after grant
    set_ch(0, 1'b0, 19'h00100, 8'h00);
    bus.ch_req[0] = 1'b1;
    push(0, 19'h00100, 8'h00);
    @(negedge clk28);
    chk("rd_latchen", 32'(bus.ch_latchen), 1);
    chk("rd_nvrd", 32'(bus.n_vrd), 0);
    chk("rd_valid_g0", 32'(bus.ch_valid[0]), 0);
    @(negedge clk28);
    chk("rd_valid_g1", 32'(bus.ch_valid[0]), 0);
    @(negedge clk28);
    chk("rd_valid_g2", 32'(bus.ch_valid[0]), 1);
    bus.ch_req[0] = 1'b0;
    @(negedge clk28);
    chk("rd_latch_clr", 32'(bus.ch_latchen), 0);
    chk("rd_nvrd_idle", 32'(bus.n_vrd), 1);
    @(negedge clk28);
    // ch0 read with address change one cycle after grant
    bus.ch_req[0] = 1'b1;
    push(0, 19'h00200, 8'h00);
    @(negedge clk28);
    bus.ch_addr[0 +: AW] = 19'h00200;
    #1 chk("mis_wait_comb", 32'(bus.ch_wait[0]), 1);
    @(negedge clk28);
    chk("mis_va", 32'(bus.va), 32'h00200);
    chk("mis_wait_s0", 32'(bus.ch_wait[0]), 1);
    chk("mis_valid_s0", 32'(bus.ch_valid[0]), 0);
    @(negedge clk28);
    chk("mis_wait_s1", 32'(bus.ch_wait[0]), 1);
    chk("mis_valid_s1", 32'(bus.ch_valid[0]), 0);
    @(negedge clk28);
    chk("mis_valid", 32'(bus.ch_valid[0]), 1);
    chk("mis_wait_drop", 32'(bus.ch_wait[0]), 0);
    bus.ch_req[0] = 1'b0;
    @(negedge clk28);
    chk("mis_wait_clear", 32'(bus.ch_wait), 0);
    @(negedge clk28);
    // stream preempted by ch2 at step 1, then re-granted
    bus.stream_addr = 19'h7C000;
    bus.stream_req  = 1'b1;
    @(negedge clk28);
    chk("st_va", 32'(bus.va), 32'h7C000);
    chk("st_ack_free", 32'(bus.stream_ack), 1);
    set_ch(2, 1'b0, 19'h00333, 8'h00);
    bus.ch_req[2] = 1'b1;
    push(2, 19'h00333, 8'h00);
    push(ST, 19'h7C000, 8'h00);
    #1 chk("st_ack_preempt", 32'(bus.stream_ack), 0);
    @(negedge clk28);
    chk("pre_latchen", 32'(bus.ch_latchen), 32'b100);
    chk("pre_va", 32'(bus.va), 32'h00333);
    chk("pre_stvalid", 32'(bus.stream_valid), 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk28);
      if (bus.stream_ack === 1'b1) begin
        cnt = 1;
        break;
      end
    end
    chk("st_ack_seen", 32'(cnt), 1);
    bus.stream_req = 1'b0;
    bus.ch_req[2]  = 1'b0;
    repeat (3) @(negedge clk28);
    chk("st_drain", 32'(sb.size()), 0);
    // simultaneous ch0 and ch2 edges: ch0 first, ch2 kept pending
    set_ch(0, 1'b0, 19'h00AAA, 8'h00);
    set_ch(2, 1'b0, 19'h00BBB, 8'h00);
    bus.ch_req = 3'b101;
    push(0, 19'h00AAA, 8'h00);
    push(2, 19'h00BBB, 8'h00);
    @(negedge clk28);
    chk("sim_first", 32'(bus.ch_latchen), 32'b001);
    repeat (3) @(negedge clk28);
    chk("sim_second", 32'(bus.ch_latchen), 32'b100);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk28);
    chk("sim_drain", 32'(sb.size()), 0);
    bus.ch_req = '0;
    repeat (2) @(negedge clk28);
    // reset in the middle of a write
    set_ch(1, 1'b1, 19'h00055, 8'h3C);
    bus.ch_req[1] = 1'b1;
    push(WR, 19'h00055, 8'h3C);
    @(negedge clk28);
    chk("rw_nvwr", 32'(bus.n_vwr), 0);
    #2 rst = 1'b1;
    #1 chk("rw_async_nvwr", 32'(bus.n_vwr), 1);
    chk("rw_async_nvrd", 32'(bus.n_vrd), 1);
    chk("rw_async_va", 32'(bus.va), 0);
    bus.ch_req = '0;
    bus.ch_we  = '0;
    @(negedge clk28);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk28);
      if (bus.n_vwr !== 1'b1 || bus.n_vrd !== 1'b1) cnt++;
    end
    chk("rw_quiet", 32'(cnt), 0);
    set_ch(0, 1'b0, 19'h00777, 8'h00);
    bus.ch_req[0] = 1'b1;
    push(0, 19'h00777, 8'h00);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk28);
    chk("final_drain", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
